// File: rtl/channel_bus_if.sv
// Shared register-bus signals between the address decoder (master) and a responder (slave).
interface channel_bus_if #(
    parameter int ADDR_W = 4,
    parameter int DATA_W = 4
);
    logic [ADDR_W-1:0] address;
    logic [DATA_W-1:0] data;
    logic              valid;
    logic              ack;
    logic [DATA_W-1:0] data_out;
    logic              data_out_valid;

    modport master (
        output address, data, valid,
        input  ack, data_out, data_out_valid
    );

    modport slave (
        input  address, data, valid,
        output ack, data_out, data_out_valid
    );
endinterface

// File: rtl/channel_controller.sv
// Multi-channel controller: channel selector, saturating per-channel levels and enable mask,
// updated by 4-address bus commands and the front-panel add pulse.
module channel_controller #(
    parameter int                NUM_CH    = 4,
    parameter int                CH_W      = 2,
    parameter int                DATA_W    = 4,
    parameter int                ADDR_W    = 4,
    parameter logic [ADDR_W-1:0] BASE_ADDR = ADDR_W'(8),
    parameter int                LEVEL_MAX = 2**DATA_W - 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [1:0]        mode,
    input  logic              add,
    channel_bus_if.slave      bus,
    output logic [CH_W-1:0]   channel,
    output logic [NUM_CH-1:0] ch_enable
);
    localparam logic [DATA_W-1:0] LVL_MAX = DATA_W'(LEVEL_MAX);
    localparam logic [1:0] OP_SELECT = 2'd0;
    localparam logic [1:0] OP_LEVEL  = 2'd1;
    localparam logic [1:0] OP_READ   = 2'd2;
    localparam logic [1:0] OP_ENABLE = 2'd3;

    typedef enum logic [1:0] {IDLE, EXEC, ACK, WAIT_DROP} state_t;

    state_t             state, state_d;
    logic [DATA_W-1:0]  level [NUM_CH];
    logic [1:0]         cmd_p1;
    logic [DATA_W-1:0]  wdata_p1;
    logic               ack_q, dout_vld_q;
    logic [DATA_W-1:0]  dout_q;

    function automatic logic [DATA_W-1:0] sat_inc(input logic [DATA_W-1:0] v);
        return (v >= LVL_MAX) ? LVL_MAX : v + 1'b1;
    endfunction

    function automatic logic [DATA_W-1:0] sat_dec(input logic [DATA_W-1:0] v);
        return (v == '0) ? '0 : v - 1'b1;
    endfunction

    function automatic logic [DATA_W-1:0] clamp(input logic [DATA_W-1:0] v);
        return (v > LVL_MAX) ? LVL_MAX : v;
    endfunction

    // First enabled index after cur, wrapping; cur itself is only kept when nothing else is enabled.
    function automatic logic [CH_W-1:0] next_channel(input logic [CH_W-1:0] cur,
                                                     input logic [NUM_CH-1:0] en);
        logic [CH_W-1:0] nxt;
        logic            found;
        nxt   = cur;
        found = 1'b0;
        for (int i = 1; i < NUM_CH; i++) begin
            int idx;
            idx = (int'(cur) + i) % NUM_CH;
            if (!found && en[idx]) begin
                nxt   = CH_W'(idx);
                found = 1'b1;
            end
        end
        return nxt;
    endfunction

    // Address decode: unsigned offset wraps high for addresses below BASE_ADDR.
    logic [ADDR_W-1:0] offset;
    logic              decoded;
    assign offset  = bus.address - BASE_ADDR;
    assign decoded = ((offset >> 2) == '0);

    logic                       exec, is_read, bus_sel, bus_lvl, bus_en;
    logic                       wdata_in_range, sel_ok;
    logic [DATA_W-1:0]          rd_val;
    logic [NUM_CH+DATA_W-1:0]   en_ext;

    assign exec           = (state == EXEC);
    assign is_read        = exec && (cmd_p1 == OP_READ);
    assign bus_sel        = exec && (cmd_p1 == OP_SELECT);
    assign bus_lvl        = exec && (cmd_p1 == OP_LEVEL);
    assign bus_en         = exec && (cmd_p1 == OP_ENABLE);
    assign wdata_in_range = (int'(wdata_p1) < NUM_CH);
    assign sel_ok         = wdata_in_range && ch_enable[wdata_p1[CH_W-1:0]];
    assign rd_val         = wdata_in_range ? level[wdata_p1[CH_W-1:0]] : '0;
    assign en_ext         = {{NUM_CH{1'b0}}, wdata_p1};

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_d;
    end

    always_comb begin
        state_d = state;
        case (state)
            IDLE:      if (bus.valid && decoded) state_d = EXEC;
            EXEC:      state_d = ACK;
            ACK:       state_d = WAIT_DROP;
            WAIT_DROP: if (!bus.valid) state_d = IDLE;
            default:   state_d = IDLE;
        endcase
    end

    // Command capture on IDLE -> EXEC
    always_ff @(posedge clk) begin
        if (state == IDLE && bus.valid && decoded) begin
            cmd_p1   <= offset[1:0];
            wdata_p1 <= bus.data;
        end
    end

    // Execute: bus command wins over a conflicting add pulse
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            channel    <= '0;
            ch_enable  <= '1;
            for (int i = 0; i < NUM_CH; i++) level[i] <= '0;
            ack_q      <= 1'b0;
            dout_vld_q <= 1'b0;
            dout_q     <= '0;
        end else begin
            ack_q      <= exec;
            dout_vld_q <= is_read;
            dout_q     <= is_read ? rd_val : '0;

            if (bus_sel) begin
                if (sel_ok) channel <= wdata_p1[CH_W-1:0];
            end else if (add && mode == 2'b01) begin
                channel <= next_channel(channel, ch_enable);
            end

            if (bus_lvl)                      level[channel] <= clamp(wdata_p1);
            else if (add && mode == 2'b10)    level[channel] <= sat_inc(level[channel]);
            else if (add && mode == 2'b11)    level[channel] <= sat_dec(level[channel]);

            if (bus_en) ch_enable <= en_ext[NUM_CH-1:0];
        end
    end

    assign bus.ack            = ack_q;
    assign bus.data_out_valid = dout_vld_q;
    assign bus.data_out       = dout_q;
endmodule

// File: tb/tb_channel_controller.sv
// Directed-vector bench for channel_controller with hand-computed expected values.
module tb_channel_controller;
    logic       clk = 1'b0;
    logic       rst;
    logic [1:0] mode;
    logic       add;
    logic [1:0] channel;
    logic [3:0] ch_enable;
    int         n_vec  = 0;
    int         n_miss = 0;

    channel_bus_if #(.ADDR_W(4), .DATA_W(4)) bus ();

    channel_controller dut (
        .clk       (clk),
        .rst       (rst),
        .mode      (mode),
        .add       (add),
        .bus       (bus),
        .channel   (channel),
        .ch_enable (ch_enable)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_miss++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Full bus transaction: ack must appear exactly two edges after valid is first sampled.
    task automatic bus_op(input logic [3:0] a, input logic [3:0] d, input logic exp_ack,
                          input logic exp_dv, input logic [3:0] exp_dout, input string tag);
        bus.address = a;
        bus.data    = d;
        bus.valid   = 1'b1;
        tick();
        check({tag, "_ack_early"}, 16'(bus.ack), 16'h0);
        tick();
        check({tag, "_ack"}, 16'(bus.ack), 16'(exp_ack));
        check({tag, "_dv"}, 16'(bus.data_out_valid), 16'(exp_dv));
        check({tag, "_dout"}, 16'(bus.data_out), 16'(exp_dout));
        tick();
        check({tag, "_ack_once"}, 16'(bus.ack), 16'h0);
        bus.valid = 1'b0;
        tick();
        tick();
    endtask

    task automatic pulse_add();
        add = 1'b1;
        tick();
        add = 1'b0;
    endtask

    int acks;

    initial begin
        rst = 1'b1; mode = 2'b00; add = 1'b0;
        bus.address = '0; bus.data = '0; bus.valid = 1'b0;
        tick(); tick();
        rst = 1'b0;
        check("rst_channel", 16'(channel), 16'h0);
        check("rst_enable", 16'(ch_enable), 16'hF);
        check("rst_ack", 16'(bus.ack), 16'h0);
        check("rst_dv", 16'(bus.data_out_valid), 16'h0);
        check("rst_dout", 16'(bus.data_out), 16'h0);

        bus_op(4'hA, 4'h2, 1'b1, 1'b1, 4'h0, "read2_after_rst");
        check("post_rst_enable", 16'(ch_enable), 16'hF);

        // Mode 01 channel stepping over mask 1010
        bus_op(4'hB, 4'hA, 1'b1, 1'b0, 4'h0, "enable_A");
        check("enable_mask", 16'(ch_enable), 16'hA);
        bus_op(4'h8, 4'h1, 1'b1, 1'b0, 4'h0, "select1");
        check("select1_ch", 16'(channel), 16'h1);
        mode = 2'b01;
        pulse_add(); check("step1", 16'(channel), 16'h3);
        pulse_add(); check("step2", 16'(channel), 16'h1);
        pulse_add(); check("step3", 16'(channel), 16'h3);
        bus_op(4'h8, 4'h2, 1'b1, 1'b0, 4'h0, "select_disabled");
        check("select_disabled_ch", 16'(channel), 16'h3);
        bus_op(4'h8, 4'h2, 1'b1, 1'b0, 4'h0, "select_disabled_again");
        check("select_disabled_ch2", 16'(channel), 16'h3);

        // Saturation up and down on channel 0
        mode = 2'b00;
        bus_op(4'hB, 4'hF, 1'b1, 1'b0, 4'h0, "enable_F");
        bus_op(4'h8, 4'h0, 1'b1, 1'b0, 4'h0, "select0");
        check("select0_ch", 16'(channel), 16'h0);
        mode = 2'b10;
        for (int i = 0; i < 17; i++) pulse_add();
        bus_op(4'hA, 4'h0, 1'b1, 1'b1, 4'hF, "level0_sat_hi");
        mode = 2'b11;
        pulse_add();
        bus_op(4'hA, 4'h0, 1'b1, 1'b1, 4'hE, "level0_dec1");
        for (int i = 0; i < 19; i++) pulse_add();
        bus_op(4'hA, 4'h0, 1'b1, 1'b1, 4'h0, "level0_sat_lo");

        // LEVEL_WR colliding with an add in mode 10 during EXEC
        mode = 2'b00;
        bus_op(4'h8, 4'h1, 1'b1, 1'b0, 4'h0, "select1b");
        mode = 2'b10;
        bus.address = 4'h9; bus.data = 4'h5; bus.valid = 1'b1;
        tick();
        add = 1'b1;
        tick();
        add = 1'b0;
        check("collide_ack", 16'(bus.ack), 16'h1);
        tick();
        bus.valid = 1'b0;
        tick(); tick();
        bus_op(4'hA, 4'h1, 1'b1, 1'b1, 4'h5, "collide_read1");
        bus_op(4'hA, 4'h0, 1'b1, 1'b1, 4'h0, "collide_read0");

        // valid held 10 cycles: one ack, one write; a later add must survive
        bus.address = 4'h9; bus.data = 4'h7; bus.valid = 1'b1;
        acks = 0;
        for (int i = 0; i < 10; i++) begin
            add = (i == 5);
            tick();
            if (bus.ack === 1'b1) acks++;
        end
        add = 1'b0;
        bus.valid = 1'b0;
        tick(); tick();
        check("held_valid_acks", 16'(acks), 16'h1);
        bus_op(4'hA, 4'h1, 1'b1, 1'b1, 4'h8, "held_valid_read");

        // Undecoded address
        mode = 2'b00;
        bus_op(4'h3, 4'h0, 1'b0, 1'b0, 4'h0, "undecoded");
        check("undecoded_enable", 16'(ch_enable), 16'hF);
        check("undecoded_channel", 16'(channel), 16'h1);
        bus_op(4'hA, 4'h1, 1'b1, 1'b1, 4'h8, "after_undecoded");

        // Reset during EXEC, then a fresh transaction from the still-high valid
        bus.address = 4'h8; bus.data = 4'h2; bus.valid = 1'b1;
        tick();
        rst = 1'b1;
        #1;
        check("mid_rst_channel", 16'(channel), 16'h0);
        check("mid_rst_enable", 16'(ch_enable), 16'hF);
        tick();
        check("mid_rst_ack", 16'(bus.ack), 16'h0);
        rst = 1'b0;
        tick();
        check("restart_ack_early", 16'(bus.ack), 16'h0);
        tick();
        check("restart_ack", 16'(bus.ack), 16'h1);
        check("restart_channel", 16'(channel), 16'h2);
        bus.valid = 1'b0;
        tick(); tick();
        bus_op(4'hA, 4'h1, 1'b1, 1'b1, 4'h0, "rst_cleared_level");

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1);
    end
endmodule
